// File: rtl/ara_pe_req_broadcaster.sv
// Holds one sequencer PE request and offers it to every PE independently,
// refreshing its hazard/running masks until each PE has taken it once.
module ara_pe_req_broadcaster #(
  parameter int unsigned NrLanes       = 1,
  parameter int unsigned NrPEs         = NrLanes + 4,
  parameter int unsigned StallCntWidth = 16,
  parameter int unsigned NrVInsn       = 8,
  parameter type pe_req_t = struct packed {
    logic [7:0]         op;
    logic [15:0]        vl;
    logic [NrVInsn-1:0] vinsn_running;
    logic [NrVInsn-1:0] hazard_vs1;
    logic [NrVInsn-1:0] hazard_vs2;
    logic [NrVInsn-1:0] hazard_vd;
    logic [NrVInsn-1:0] hazard_vm;
  }
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  pe_req_t                  pe_req_i,
  input  logic                     pe_req_valid_i,
  output logic                     pe_req_ready_o,
  input  logic [NrVInsn-1:0]       vinsn_running_i,
  output pe_req_t                  pe_req_o,
  output logic [NrPEs-1:0]         pe_req_valid_o,
  input  logic [NrPEs-1:0]         pe_req_ready_i,
  output logic                     busy_o,
  output logic [StallCntWidth-1:0] stall_cnt_o
);

  // Handshakes: a transfer happens on any edge where valid and ready are both
  // high. Upstream ready never depends on pe_req_valid_i; each PE bit is
  // offered until that PE accepts once, then stays low until the next capture.

  typedef enum logic {IDLE, BCAST} state_e;

  localparam logic [StallCntWidth-1:0] CntOne = 1;

  state_e                   state_q, state_d;
  logic [NrPEs-1:0]         acc_q, acc_d;
  pe_req_t                  req_q, req_d;
  logic [StallCntWidth-1:0] cnt_q, cnt_d;

  logic [NrPEs-1:0] accept;
  logic             all_done;
  logic             capture;

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    req_d          = req_q;
    cnt_d          = cnt_q;
    pe_req_valid_o = '0;
    all_done       = 1'b0;

    if (state_q == BCAST) begin
      pe_req_valid_o = ~acc_q;
    end
    accept = pe_req_valid_o & pe_req_ready_i;
    if (state_q == BCAST) begin
      all_done = &(acc_q | accept);
    end

    pe_req_ready_o = !rst_i && ((state_q == IDLE) || all_done);
    capture        = pe_req_valid_i && pe_req_ready_o;

    if (state_q == BCAST) begin
      acc_d                = acc_q | accept;
      // Hazards can only retire while held; masking keeps them monotonic.
      req_d.vinsn_running  = vinsn_running_i;
      req_d.hazard_vs1     = req_q.hazard_vs1 & vinsn_running_i;
      req_d.hazard_vs2     = req_q.hazard_vs2 & vinsn_running_i;
      req_d.hazard_vd      = req_q.hazard_vd  & vinsn_running_i;
      req_d.hazard_vm      = req_q.hazard_vm  & vinsn_running_i;
      if (!all_done && !(&cnt_q)) begin
        cnt_d = cnt_q + CntOne;
      end
      if (all_done) begin
        state_d = IDLE;
      end
    end

    if (capture) begin
      req_d   = pe_req_i;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = BCAST;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      req_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pe_req_o    = req_q;
  assign busy_o      = (state_q == BCAST);
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_ara_pe_req_broadcaster.sv
// Self-checking bench for ara_pe_req_broadcaster with 4 lanes (8 PEs) and a
// 4-bit stall counter so saturation is reachable quickly.
module tb_ara_pe_req_broadcaster;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] vl;
    logic [7:0]  vinsn_running;
    logic [7:0]  hazard_vs1;
    logic [7:0]  hazard_vs2;
    logic [7:0]  hazard_vd;
    logic [7:0]  hazard_vm;
  } req_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  req_t       pe_req_i;
  logic       pe_req_valid_i;
  logic       pe_req_ready_o;
  logic [7:0] vinsn_running_i;
  req_t       pe_req_o;
  logic [7:0] pe_req_valid_o;
  logic [7:0] pe_req_ready_i;
  logic       busy_o;
  logic [3:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  ara_pe_req_broadcaster #(
    .NrLanes(4),
    .StallCntWidth(4),
    .NrVInsn(8),
    .pe_req_t(req_t)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .pe_req_i(pe_req_i),
    .pe_req_valid_i(pe_req_valid_i),
    .pe_req_ready_o(pe_req_ready_o),
    .vinsn_running_i(vinsn_running_i),
    .pe_req_o(pe_req_o),
    .pe_req_valid_o(pe_req_valid_o),
    .pe_req_ready_i(pe_req_ready_i),
    .busy_o(busy_o),
    .stall_cnt_o(stall_cnt_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Scoreboard: push {op,vl} on every upstream handshake, pop on the first
  // offer cycle (all PE valids high) and compare against the held request.
  always @(negedge clk_i) begin
    if (!rst_i && pe_req_valid_i && pe_req_ready_o) begin
      exp_q.push_back({pe_req_i.op, pe_req_i.vl});
    end
    if (busy_o && pe_req_valid_o == 8'hFF) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_offer: got op/vl %h, expected queue empty", {pe_req_o.op, pe_req_o.vl});
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if ({pe_req_o.op, pe_req_o.vl} !== e) begin
          errors++;
          $display("FAIL sb_offer: got op/vl %h, expected %h", {pe_req_o.op, pe_req_o.vl}, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic make_req(input logic [7:0] op, input logic [15:0] vl, output req_t r);
    r = '0;
    r.op = op;
    r.vl = vl;
    r.vinsn_running = 8'h06;
    r.hazard_vs1 = 8'h01;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    pe_req_valid_i = 1'b0;
    pe_req_i = '0;
    pe_req_ready_i = 8'h00;
    vinsn_running_i = 8'h00;
    repeat (3) next_cycle();
    @(negedge clk_i);
    checks++;
    if (pe_req_valid_o !== 8'h00 || busy_o !== 1'b0 || pe_req_ready_o !== 1'b0 ||
        stall_cnt_o !== 4'h0 || pe_req_o !== req_t'(0)) begin
      errors++;
      $display("FAIL reset_state: valid=%h busy=%b ready=%b stall=%h req=%h, expected 00/0/0/0/0",
               pe_req_valid_o, busy_o, pe_req_ready_o, stall_cnt_o, pe_req_o);
    end
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (pe_req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, expected 1", pe_req_ready_o);
    end
  endtask

  task automatic test_single();
    req_t r;
    next_cycle();
    make_req(8'h11, 16'd16, r);
    pe_req_i = r;
    pe_req_valid_i = 1'b1;
    pe_req_ready_i = 8'hFF;
    @(negedge clk_i);
    checks++;
    if (pe_req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL single_c0_ready: got %b, expected 1", pe_req_ready_o);
    end
    next_cycle();
    pe_req_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (pe_req_valid_o !== 8'hFF || pe_req_ready_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_c1: valid=%h ready=%b busy=%b, expected ff/1/1",
               pe_req_valid_o, pe_req_ready_o, busy_o);
    end
    next_cycle();
    @(negedge clk_i);
    checks++;
    if (pe_req_valid_o !== 8'h00 || busy_o !== 1'b0 || stall_cnt_o !== 4'h0) begin
      errors++;
      $display("FAIL single_c2: valid=%h busy=%b stall=%h, expected 00/0/0",
               pe_req_valid_o, busy_o, stall_cnt_o);
    end
  endtask

  task automatic test_staggered();
    req_t r;
    logic [7:0] rdy_tab [1:4];
    logic [7:0] vld_tab [1:4];
    logic       go_tab  [1:4];
    // Cycle 2 re-raises ready on PEs that already accepted; it must be ignored.
    rdy_tab = '{8'h0F, 8'h0F, 8'h20, 8'hD0};
    vld_tab = '{8'hFF, 8'hF0, 8'hF0, 8'hD0};
    go_tab  = '{1'b0, 1'b0, 1'b0, 1'b1};
    next_cycle();
    make_req(8'h22, 16'd32, r);
    pe_req_i = r;
    pe_req_valid_i = 1'b1;
    pe_req_ready_i = 8'h00;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      pe_req_valid_i = 1'b0;
      pe_req_ready_i = rdy_tab[c];
      @(negedge clk_i);
      checks++;
      if (pe_req_valid_o !== vld_tab[c] || pe_req_ready_o !== go_tab[c]) begin
        errors++;
        $display("FAIL stagger_c%0d: valid=%h ready=%b, expected %h/%b",
                 c, pe_req_valid_o, pe_req_ready_o, vld_tab[c], go_tab[c]);
      end
    end
    next_cycle();
    pe_req_ready_i = 8'h00;
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || stall_cnt_o !== 4'd3) begin
      errors++;
      $display("FAIL stagger_done: busy=%b stall=%0d, expected 0/3", busy_o, stall_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    req_t a, b;
    next_cycle();
    make_req(8'hA0, 16'd100, a);
    make_req(8'hB0, 16'd200, b);
    pe_req_i = a;
    pe_req_valid_i = 1'b1;
    pe_req_ready_i = 8'hFF;
    @(negedge clk_i);
    checks++;
    if (pe_req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_c0_ready: got %b, expected 1", pe_req_ready_o);
    end
    next_cycle();
    pe_req_i = b;
    @(negedge clk_i);
    checks++;
    if (pe_req_o.op !== 8'hA0 || pe_req_valid_o !== 8'hFF || pe_req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_c1: op=%h valid=%h ready=%b, expected a0/ff/1",
               pe_req_o.op, pe_req_valid_o, pe_req_ready_o);
    end
    next_cycle();
    pe_req_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (pe_req_o.op !== 8'hB0 || pe_req_valid_o !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_c2: op=%h valid=%h, expected b0/ff", pe_req_o.op, pe_req_valid_o);
    end
    next_cycle();
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_c3_idle: busy=%b, expected 0", busy_o);
    end
  endtask

  task automatic test_hazard_refresh();
    req_t r;
    next_cycle();
    make_req(8'h5A, 16'd64, r);
    r.hazard_vs1 = 8'b0000_0110;
    r.hazard_vd  = 8'h03;
    pe_req_i = r;
    pe_req_valid_i = 1'b1;
    pe_req_ready_i = 8'h00;
    vinsn_running_i = 8'h06;
    next_cycle();
    pe_req_valid_i = 1'b0;
    pe_req_ready_i = 8'h7F;
    @(negedge clk_i);
    checks++;
    if (pe_req_o.hazard_vs1 !== 8'h06 || pe_req_o.hazard_vd !== 8'h03) begin
      errors++;
      $display("FAIL haz_c1: vs1=%h vd=%h, expected 06/03", pe_req_o.hazard_vs1, pe_req_o.hazard_vd);
    end
    next_cycle();
    pe_req_ready_i = 8'h00;
    vinsn_running_i = 8'h04;
    @(negedge clk_i);
    checks++;
    if (pe_req_o.hazard_vs1 !== 8'h06 || pe_req_o.hazard_vd !== 8'h02) begin
      errors++;
      $display("FAIL haz_c2: vs1=%h vd=%h, expected 06/02", pe_req_o.hazard_vs1, pe_req_o.hazard_vd);
    end
    next_cycle();
    vinsn_running_i = 8'h06;
    @(negedge clk_i);
    checks++;
    if (pe_req_o.hazard_vs1 !== 8'h04 || pe_req_o.hazard_vd !== 8'h00 ||
        pe_req_o.vinsn_running !== 8'h04 || pe_req_o.op !== 8'h5A || pe_req_o.vl !== 16'd64) begin
      errors++;
      $display("FAIL haz_c3: vs1=%h vd=%h run=%h op=%h vl=%0d, expected 04/00/04/5a/64",
               pe_req_o.hazard_vs1, pe_req_o.hazard_vd, pe_req_o.vinsn_running,
               pe_req_o.op, pe_req_o.vl);
    end
    next_cycle();
    @(negedge clk_i);
    checks++;
    if (pe_req_o.hazard_vs1 !== 8'h04 || pe_req_o.vinsn_running !== 8'h06) begin
      errors++;
      $display("FAIL haz_no_reset: vs1=%h run=%h, expected 04/06",
               pe_req_o.hazard_vs1, pe_req_o.vinsn_running);
    end
    next_cycle();
    pe_req_ready_i = 8'h80;
    @(negedge clk_i);
    checks++;
    if (pe_req_valid_o !== 8'h80 || pe_req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL haz_release: valid=%h ready=%b, expected 80/1", pe_req_valid_o, pe_req_ready_o);
    end
    next_cycle();
    pe_req_ready_i = 8'h00;
  endtask

  task automatic test_saturation();
    req_t r;
    logic [3:0] exp_cnt;
    next_cycle();
    make_req(8'h77, 16'd8, r);
    pe_req_i = r;
    pe_req_valid_i = 1'b1;
    pe_req_ready_i = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      pe_req_valid_i = 1'b0;
      pe_req_ready_i = (c == 1) ? 8'h7F : 8'h00;
      exp_cnt = (c - 1 > 15) ? 4'hF : 4'(c - 1);
      @(negedge clk_i);
      checks++;
      if (stall_cnt_o !== exp_cnt || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL sat_c%0d: stall=%h busy=%b, expected %h/1", c, stall_cnt_o, busy_o, exp_cnt);
      end
    end
    next_cycle();
    pe_req_ready_i = 8'h80;
    next_cycle();
    pe_req_ready_i = 8'h00;
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || stall_cnt_o !== 4'hF) begin
      errors++;
      $display("FAIL sat_hold: busy=%b stall=%h, expected 0/f", busy_o, stall_cnt_o);
    end
    make_req(8'h78, 16'd9, r);
    pe_req_i = r;
    pe_req_valid_i = 1'b1;
    pe_req_ready_i = 8'hFF;
    next_cycle();
    pe_req_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (stall_cnt_o !== 4'h0 || pe_req_valid_o !== 8'hFF) begin
      errors++;
      $display("FAIL sat_clear: stall=%h valid=%h, expected 0/ff", stall_cnt_o, pe_req_valid_o);
    end
    next_cycle();
    pe_req_ready_i = 8'h00;
  endtask

  task automatic test_reset_mid();
    req_t r;
    next_cycle();
    make_req(8'h99, 16'd4, r);
    pe_req_i = r;
    pe_req_valid_i = 1'b1;
    pe_req_ready_i = 8'h00;
    next_cycle();
    pe_req_valid_i = 1'b0;
    pe_req_ready_i = 8'h0F;
    next_cycle();
    pe_req_ready_i = 8'h00;
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (pe_req_ready_o !== 1'b0 || pe_req_valid_o !== 8'hF0) begin
      errors++;
      $display("FAIL rstmid_c2: ready=%b valid=%h, expected 0/f0", pe_req_ready_o, pe_req_valid_o);
    end
    next_cycle();
    @(negedge clk_i);
    checks++;
    if (pe_req_valid_o !== 8'h00 || busy_o !== 1'b0 || pe_req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_c3: valid=%h busy=%b ready=%b, expected 00/0/0",
               pe_req_valid_o, busy_o, pe_req_ready_o);
    end
    next_cycle();
    rst_i = 1'b0;
    pe_req_ready_i = 8'($urandom_range(0, 255));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checks++;
      if (pe_req_ready_o !== 1'b1 || pe_req_valid_o !== 8'h00 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_after%0d: ready=%b valid=%h busy=%b, expected 1/00/0",
                 c, pe_req_ready_o, pe_req_valid_o, busy_o);
      end
      next_cycle();
    end
    pe_req_ready_i = 8'h00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_staggered();
    test_back_to_back();
    test_hazard_refresh();
    test_saturation();
    test_reset_mid();
    repeat (2) next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d requests never offered, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
